// File: rtl/line_buffer_3x3_pkg.sv
// Shared definitions for the 3x3 line buffer: FSM encoding, size defaults,
// coordinate width and the frame-dimension check.
package line_buffer_3x3_pkg;

  localparam int LB_DW    = 8;
  localparam int LB_MAX_W = 640;
  localparam int CW       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } lb_state_t;

  typedef struct packed {
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } dims_t;

  function automatic logic dims_ok(input logic [CW-1:0] w, input logic [CW-1:0] h,
                                   input int max_w);
    return (w >= 16'd3) && (int'(w) <= max_w) && (h >= 16'd3);
  endfunction

endpackage

// File: rtl/lb_line_ram.sv
// Single-port line memory, one pixel per column, read-before-write.
// Latency: combinational read of the old word, write lands on the clock edge.
// Backpressure: none; the owner writes every accepted pixel.
module lb_line_ram
  import line_buffer_3x3_pkg::*;
#(
  parameter int DEPTH = LB_MAX_W,
  parameter int DW    = LB_DW,
  parameter int AW    = $clog2(LB_MAX_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdat,
  output logic [DW-1:0] rdat
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately not reset: rows 0-1 of every frame are
  // rewritten before any window can use them.
  assign rdat = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdat;
    end
  end

endmodule

// File: rtl/line_buffer_3x3.sv
// 3x3 sliding-window generator over a raster grayscale stream (sobel ordering).
// Latency: window for pixel (r,c) is presented 1 cycle after that pixel is accepted.
// Backpressure: none; idle input cycles freeze all state.
module line_buffer_3x3
  import line_buffer_3x3_pkg::*;
#(
  parameter int MAX_W = LB_MAX_W,
  parameter int DW    = LB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pixel,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] height,
  output logic          out_valid,
  output logic [DW-1:0] data0,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [DW-1:0] data3,
  output logic [DW-1:0] data4,
  output logic [DW-1:0] data5,
  output logic [DW-1:0] data6,
  output logic [DW-1:0] data7,
  output logic [DW-1:0] data8,
  output logic [CW-1:0] out_col,
  output logic [CW-1:0] out_row,
  output logic          frame_done,
  output logic          dim_err
);

  localparam int AW = $clog2(MAX_W);

  lb_state_t     state_q, state_d;
  dims_t         dims_q;
  logic [CW-1:0] col_q, row_q;
  logic [CW-1:0] pix_col, pix_row, w_use, h_use;
  logic          start, acc, last, qual;
  logic [DW-1:0] line1_rd, line2_rd;
  // Two stored columns plus the incoming column form the 3x3 window.
  logic [DW-1:0] win_q [3][2];
  logic [DW-1:0] win_d [3][3];
  logic [DW-1:0] dat_q [9];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    acc     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (in_valid) begin
          start = 1'b1;
          if (dims_ok(width, height, MAX_W)) begin
            acc     = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN:  acc = in_valid;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
    // A frame-starting pixel is (0,0) and uses the live dimensions.
    pix_col = start ? '0 : col_q;
    pix_row = start ? '0 : row_q;
    w_use   = start ? width  : dims_q.w;
    h_use   = start ? height : dims_q.h;
    last    = (pix_col == w_use - 16'd1) && (pix_row == h_use - 16'd1);
    qual    = (pix_col >= 16'd2) && (pix_row >= 16'd2);
    if (acc && last) begin
      state_d = ST_DONE;
    end
  end

  // line1 holds row r-1, line2 holds row r-2; line1's old word shifts down.
  lb_line_ram #(.DEPTH(MAX_W), .DW(DW), .AW(AW)) u_line1 (
    .clk  (clk),
    .we   (acc),
    .addr (pix_col[AW-1:0]),
    .wdat (in_pixel),
    .rdat (line1_rd)
  );

  lb_line_ram #(.DEPTH(MAX_W), .DW(DW), .AW(AW)) u_line2 (
    .clk  (clk),
    .we   (acc),
    .addr (pix_col[AW-1:0]),
    .wdat (line1_rd),
    .rdat (line2_rd)
  );

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][0];
      win_d[r][1] = win_q[r][1];
    end
    win_d[0][2] = line2_rd;
    win_d[1][2] = line1_rd;
    win_d[2][2] = in_pixel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dims_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      for (int i = 0; i < 9; i++) begin
        dat_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else begin
      out_valid  <= acc && qual;
      frame_done <= acc && last;
      if (start) begin
        dims_q <= '{w: width, h: height};
      end
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_d[r][1];
          win_q[r][1] <= win_d[r][2];
        end
        if (last) begin
          col_q <= '0;
          row_q <= '0;
        end else if (pix_col == w_use - 16'd1) begin
          col_q <= '0;
          row_q <= pix_row + 16'd1;
        end else begin
          col_q <= pix_col + 16'd1;
          row_q <= pix_row;
        end
        // Output registers load only on emitted windows so they hold otherwise.
        if (qual) begin
          for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
              dat_q[r*3+k] <= win_d[r][k];
            end
          end
          out_col <= pix_col - 16'd1;
          out_row <= pix_row - 16'd1;
        end
      end
    end
  end

  assign dim_err = (state_q == ST_ERR);

  assign data0 = dat_q[0];
  assign data1 = dat_q[1];
  assign data2 = dat_q[2];
  assign data3 = dat_q[3];
  assign data4 = dat_q[4];
  assign data5 = dat_q[5];
  assign data6 = dat_q[6];
  assign data7 = dat_q[7];
  assign data8 = dat_q[8];

endmodule

// File: doc/line_buffer_3x3.md
LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

Interface
REQ-001 Parameter MAX_W, default 640, maximum supported line width in pixels.
REQ-002 Parameter DW, default 8, grayscale pixel width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: in_pixel is valid this cycle (one raster-order pixel from rgb2gray).
REQ-006 Port in_pixel, input, DW: grayscale pixel.
REQ-007 Port width, input, 16: frame width in pixels; sampled at frame start.
REQ-008 Port height, input, 16: frame height in lines; sampled at frame start.
REQ-009 Port out_valid, output, 1: data0..data8, out_col and out_row are valid this cycle.
REQ-010 Ports data0..data8, output, DW each: 3x3 window in row-major order, with data0 top-left, data4 centre and data8 bottom-right (sobel ordering).
REQ-011 Ports out_col and out_row, output, 16 each: coordinates of the window centre pixel.
REQ-012 Port frame_done, output, 1: one-cycle pulse after the last window of a frame.
REQ-013 Port dim_err, output, 1: sticky flag for unsupported dimensions.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE and ERR.
REQ-015 IDLE: on in_valid, latch width and height. If 3<=width<=MAX_W and height>=3, go to RUN and store the pixel as (row 0, col 0); otherwise go to ERR.
REQ-016 RUN: each in_valid pixel SHALL advance col. At col==W-1, col wraps to 0 and row increments.
REQ-017 The block SHALL hold two line memories of MAX_W x DW (rows r-1 and r-2), read and written at index col, plus a 3x3 shift register fed from {line2, line1, in_pixel}.
REQ-018 For an accepted pixel at (r, c) with r>=2 and c>=2, out_valid SHALL assert exactly 1 cycle later, with out_row=r-1, out_col=c-1 and the window covering rows r-2..r and cols c-2..c.
REQ-019 No window SHALL be emitted that straddles a line wrap; edge pixels produce no output, giving (W-2)*(H-2) windows per frame.
REQ-020 out_valid SHALL be low in any cycle without a qualifying input on the previous cycle; there is no backpressure.
REQ-021 Gaps in in_valid SHALL freeze all state; the outputs return to out_valid=0 while data0..data8 hold their values.
REQ-022 When the pixel at (H-1, W-1) is accepted, go to DONE; frame_done pulses in the cycle the final out_valid is high, and the FSM returns to IDLE the next cycle.
REQ-023 in_valid while in DONE SHALL be treated as the first pixel of the next frame (IDLE behaviour).
REQ-024 ERR: ignore input and hold dim_err=1 until reset.
REQ-025 width and height changes mid-frame SHALL be ignored.
REQ-026 Counters SHALL be 16-bit unsigned; comparisons use the latched dimensions.

Reset
REQ-027 When reset is high, the FSM SHALL go to IDLE, and row, col, out_valid, frame_done and dim_err SHALL be 0.
REQ-028 When reset is high, data0..data8, out_col and out_row SHALL be 0.
REQ-029 Line memory contents are not reset and SHALL never appear at the outputs, because rows 0-1 are always rewritten before use.
REQ-030 Reset mid-frame SHALL abort the frame; the next in_valid starts a new frame at (0,0).

Structure
REQ-031 A shared package SHALL hold the state encoding, DW and MAX_W defaults, and the coordinate width (16).
REQ-032 One sub-module, lb_line_ram (single-port, read-before-write, MAX_W x DW), SHALL be instantiated twice.

Verification
REQ-033 4x4 frame with pixels 0..15 streamed continuously -> 4 windows. The first window (row 1, col 1) is {0,1,2,4,5,6,8,9,10}; the last (row 2, col 2) is {5,6,7,9,10,11,13,14,15}. frame_done coincides with the 4th out_valid.
REQ-034 Same 4x4 frame with in_valid toggled every other cycle -> identical windows in the same order, each one cycle after its qualifying pixel.
REQ-035 width=2 or width=MAX_W+1 -> dim_err=1 and out_valid never asserts; reset clears dim_err.
REQ-036 Reset asserted after 7 pixels of a 4x4 frame, then a fresh 3x3 frame of value 9 -> exactly one window, all 9s, at (1,1).
REQ-037 Two back-to-back 3x3 frames (9 consecutive pixels each) -> two windows and two frame_done pulses, with no dropped first pixel on frame two.
REQ-038 640x3 ramp (pixel = col mod 256) -> 638 windows, window k having columns k, k+1, k+2.
